// File: rtl/slot_game_ctrl.sv
// Four-reel slot machine controller: credit bank, spin sequencing with timed reel
// stops, payout evaluation and a saturating credit balance.
module slot_game_ctrl #(
    parameter int unsigned SPIN_TICKS = 50,
    parameter int unsigned STOP_GAP   = 25,
    parameter int unsigned SPIN_COST  = 10,
    parameter int unsigned BANK_MAX   = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        coin_1,
    input  logic        coin_10,
    input  logic        coin_50,
    input  logic        coin_100,
    input  logic        spin,
    input  logic [3:0]  rnd1,
    input  logic [3:0]  rnd2,
    input  logic [3:0]  rnd3,
    input  logic [3:0]  rnd4,
    output logic [3:0]  reel_run,
    output logic [3:0]  disp1,
    output logic [3:0]  disp2,
    output logic [3:0]  disp3,
    output logic [3:0]  disp4,
    output logic [13:0] bank,
    output logic        busy,
    output logic        win,
    output logic [10:0] win_amt,
    output logic        no_credit
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned ARITH_W = 16;
    localparam int unsigned BANK_W  = 14;
    localparam int unsigned AMT_W   = 11;

    localparam logic [CNT_W-1:0]   SPIN_LAST  = CNT_W'(SPIN_TICKS - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(STOP_GAP - 1);
    localparam logic [ARITH_W-1:0] COST_A     = ARITH_W'(SPIN_COST);
    localparam logic [ARITH_W-1:0] BANK_MAX_A = ARITH_W'(BANK_MAX);

    typedef enum logic [2:0] {
        IDLE,
        SPIN,
        STOP,
        EVAL,
        PAY
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         idx, idx_nxt;
    logic [3:0]         reel_run_nxt;
    logic [3:0][3:0]    held, held_nxt;
    logic [AMT_W-1:0]   win_amt_nxt;
    logic               win_nxt;
    logic               no_credit_nxt;
    logic [BANK_W-1:0]  bank_nxt;
    logic               busy_nxt;

    logic               accept;
    logic [AMT_W-1:0]   payout;
    logic [ARITH_W-1:0] coin_sum;
    logic [ARITH_W-1:0] bank_sum;
    logic [3:0][3:0]    rnd_all;

    assign rnd_all = {rnd4, rnd3, rnd2, rnd1};

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            reel_run  <= '0;
            held      <= '0;
            win_amt   <= '0;
            win       <= 1'b0;
            no_credit <= 1'b0;
            bank      <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            reel_run  <= reel_run_nxt;
            held      <= held_nxt;
            win_amt   <= win_amt_nxt;
            win       <= win_nxt;
            no_credit <= no_credit_nxt;
            bank      <= bank_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state, reel sequencing and bank arithmetic
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        idx_nxt       = idx;
        reel_run_nxt  = reel_run;
        held_nxt      = held;
        win_amt_nxt   = win_amt;
        win_nxt       = 1'b0;
        no_credit_nxt = 1'b0;
        accept        = 1'b0;
        payout        = '0;

        case (state)
            IDLE: begin
                if (spin) begin
                    // Acceptance uses the balance before this cycle's coins
                    if (ARITH_W'(bank) >= COST_A) begin
                        accept       = 1'b1;
                        reel_run_nxt = 4'b1111;
                        cnt_nxt      = '0;
                        idx_nxt      = '0;
                        state_nxt    = SPIN;
                    end else begin
                        no_credit_nxt = 1'b1;
                    end
                end
            end
            SPIN: begin
                if (tick) begin
                    if (cnt == SPIN_LAST) begin
                        reel_run_nxt[0] = 1'b0;
                        held_nxt[0]     = rnd1;
                        idx_nxt         = 2'd1;
                        cnt_nxt         = '0;
                        state_nxt       = STOP;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (cnt == GAP_LAST) begin
                        reel_run_nxt[idx] = 1'b0;
                        held_nxt[idx]     = rnd_all[idx];
                        if (idx == 2'd3) begin
                            state_nxt = EVAL;
                        end else begin
                            idx_nxt = idx + 2'd1;
                            cnt_nxt = '0;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            EVAL: begin
                if (held[0] == held[1] && held[1] == held[2] && held[2] == held[3]) begin
                    win_amt_nxt = AMT_W'(1000);
                end else if (held[0] == held[1] && held[1] == held[2]) begin
                    win_amt_nxt = AMT_W'(100);
                end else if (held[0] == held[1]) begin
                    win_amt_nxt = AMT_W'(20);
                end else begin
                    win_amt_nxt = '0;
                end
                state_nxt = PAY;
            end
            PAY: begin
                payout    = win_amt;
                win_nxt   = (win_amt != '0);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);

        coin_sum = (coin_1   ? ARITH_W'(1)   : '0)
                 + (coin_10  ? ARITH_W'(10)  : '0)
                 + (coin_50  ? ARITH_W'(50)  : '0)
                 + (coin_100 ? ARITH_W'(100) : '0);

        // Cost only subtracted on accept, which guarantees bank >= cost: no underflow
        bank_sum = ARITH_W'(bank) + coin_sum + ARITH_W'(payout) - (accept ? COST_A : '0);
        bank_nxt = (bank_sum > BANK_MAX_A) ? BANK_W'(BANK_MAX_A) : BANK_W'(bank_sum);
    end

    // Live digit while spinning, latched digit once stopped
    assign disp1 = reel_run[0] ? rnd1 : held[0];
    assign disp2 = reel_run[1] ? rnd2 : held[1];
    assign disp3 = reel_run[2] ? rnd3 : held[2];
    assign disp4 = reel_run[3] ? rnd4 : held[3];

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Directed bench for slot_game_ctrl with short reel timing (SPIN_TICKS=2, STOP_GAP=1).
module tb_slot_game_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        coin_1, coin_10, coin_50, coin_100;
    logic        spin;
    logic [3:0]  rnd1, rnd2, rnd3, rnd4;
    logic [3:0]  reel_run;
    logic [3:0]  disp1, disp2, disp3, disp4;
    logic [13:0] bank;
    logic        busy;
    logic        win;
    logic [10:0] win_amt;
    logic        no_credit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slot_game_ctrl #(
        .SPIN_TICKS(2),
        .STOP_GAP  (1),
        .SPIN_COST (10),
        .BANK_MAX  (9999)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .coin_1   (coin_1),
        .coin_10  (coin_10),
        .coin_50  (coin_50),
        .coin_100 (coin_100),
        .spin     (spin),
        .rnd1     (rnd1),
        .rnd2     (rnd2),
        .rnd3     (rnd3),
        .rnd4     (rnd4),
        .reel_run (reel_run),
        .disp1    (disp1),
        .disp2    (disp2),
        .disp3    (disp3),
        .disp4    (disp4),
        .bank     (bank),
        .busy     (busy),
        .win      (win),
        .win_amt  (win_amt),
        .no_credit(no_credit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are observed 1 time unit after it
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b0;
        repeat (3) cycle();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    task automatic set_rnd(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        rnd1 = a; rnd2 = b; rnd3 = c; rnd4 = d;
    endtask

    // Full spin: start, five reel ticks, EVAL, PAY
    task automatic run_spin(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        set_rnd(a, b, c, d);
        spin = 1'b1;
        cycle();
        spin = 1'b0;
        repeat (5) do_tick();
        cycle();
        cycle();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; spin = 1'b0;
        coin_1 = 1'b0; coin_10 = 1'b0; coin_50 = 1'b0; coin_100 = 1'b0;
        set_rnd(4'd0, 4'd0, 4'd0, 4'd0);
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_bank", 32'(bank), 32'd0);
        check("rst_reel_run", 32'(reel_run), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_win_amt", 32'(win_amt), 32'd0);
        check("rst_disp", 32'({disp4, disp3, disp2, disp1}), 32'h0000);

        // Simultaneous coins are summed
        coin_100 = 1'b1; coin_50 = 1'b1; coin_1 = 1'b1;
        cycle();
        coin_100 = 1'b0; coin_50 = 1'b0; coin_1 = 1'b0;
        check("coins_sum", 32'(bank), 32'd151);

        set_rnd(4'd7, 4'd7, 4'd7, 4'd7);
        spin = 1'b1;
        cycle();
        spin = 1'b0;
        check("spin_bank", 32'(bank), 32'd141);
        check("spin_busy", 32'(busy), 32'd1);
        check("spin_reels", 32'(reel_run), 32'b1111);

        do_tick();
        check("tick1_reels", 32'(reel_run), 32'b1111);
        spin = 1'b1;
        cycle();
        spin = 1'b0;
        check("busy_spin_ignored", 32'(bank), 32'd141);

        do_tick();
        check("tick2_reels", 32'(reel_run), 32'b1110);
        rnd1 = 4'd9;
        check("disp1_held", 32'(disp1), 32'd7);
        check("disp2_live", 32'(disp2), 32'd7);
        do_tick();
        check("tick3_reels", 32'(reel_run), 32'b1100);
        do_tick();
        check("tick4_reels", 32'(reel_run), 32'b1000);
        do_tick();
        check("tick5_reels", 32'(reel_run), 32'b0000);
        check("stopped_disp", 32'({disp4, disp3, disp2, disp1}), 32'h7777);
        check("pre_eval_busy", 32'(busy), 32'd1);
        cycle();
        check("eval_win_amt", 32'(win_amt), 32'd1000);
        check("eval_win", 32'(win), 32'd0);
        cycle();
        check("pay_bank", 32'(bank), 32'd1141);
        check("pay_win", 32'(win), 32'd1);
        check("pay_idle", 32'(busy), 32'd0);
        cycle();
        check("win_single", 32'(win), 32'd0);

        run_spin(4'd3, 4'd3, 4'd3, 4'd5);
        check("three_amt", 32'(win_amt), 32'd100);
        check("three_bank", 32'(bank), 32'd1231);
        check("three_win", 32'(win), 32'd1);

        run_spin(4'd3, 4'd3, 4'd4, 4'd5);
        check("pair_amt", 32'(win_amt), 32'd20);
        check("pair_bank", 32'(bank), 32'd1241);

        run_spin(4'd1, 4'd2, 4'd1, 4'd1);
        check("lose_amt", 32'(win_amt), 32'd0);
        check("lose_bank", 32'(bank), 32'd1231);
        check("lose_win", 32'(win), 32'd0);

        // Insufficient credit; coins in the same cycle do not count toward acceptance
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        coin_1 = 1'b1;
        repeat (5) cycle();
        coin_1 = 1'b0;
        check("low_bank", 32'(bank), 32'd5);
        spin = 1'b1;
        coin_10 = 1'b1;
        cycle();
        spin = 1'b0;
        coin_10 = 1'b0;
        check("no_credit_pulse", 32'(no_credit), 32'd1);
        check("no_credit_bank", 32'(bank), 32'd15);
        check("no_credit_busy", 32'(busy), 32'd0);
        check("no_credit_reels", 32'(reel_run), 32'd0);
        cycle();
        check("no_credit_single", 32'(no_credit), 32'd0);

        // Abort mid-spin with reset
        set_rnd(4'd9, 4'd9, 4'd9, 4'd9);
        spin = 1'b1;
        cycle();
        spin = 1'b0;
        check("abort_start_bank", 32'(bank), 32'd5);
        repeat (3) do_tick();
        check("abort_reels_pre", 32'(reel_run), 32'b1100);
        rst = 1'b1;
        spin = 1'b1;
        cycle();
        rst = 1'b0;
        spin = 1'b0;
        check("abort_reels", 32'(reel_run), 32'd0);
        check("abort_bank", 32'(bank), 32'd0);
        check("abort_disp", 32'({disp4, disp3, disp2, disp1}), 32'h0000);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_credit", 32'(no_credit), 32'd0);

        // Saturation at BANK_MAX
        coin_100 = 1'b1;
        repeat (100) cycle();
        coin_100 = 1'b0;
        check("sat_coins", 32'(bank), 32'd9999);
        set_rnd(4'd7, 4'd7, 4'd7, 4'd7);
        spin = 1'b1;
        cycle();
        spin = 1'b0;
        check("sat_spin_bank", 32'(bank), 32'd9989);
        coin_1 = 1'b1;
        cycle();
        coin_1 = 1'b0;
        check("sat_pre_bank", 32'(bank), 32'd9990);
        repeat (5) do_tick();
        cycle();
        coin_100 = 1'b1;
        cycle();
        coin_100 = 1'b0;
        check("sat_pay_bank", 32'(bank), 32'd9999);
        check("sat_win", 32'(win), 32'd1);
        check("sat_win_amt", 32'(win_amt), 32'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
